// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Largest value a 4-digit display can show.
  localparam int unsigned BCD_MAX = 32'd9999;

  // Packed BCD word shown when the input exceeds BCD_MAX.
  localparam logic [15:0] BCD_SAT = 16'h9999;

  // Digits in the internal accumulator; the fifth digit never reaches the output.
  localparam int BCD_DIGITS_INT = 5;

endpackage : bcd_pkg

// File: rtl/bcd_adj3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so
// that the following left shift carries correctly into the next digit.
module bcd_adj3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  assign fixed = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule : bcd_adj3

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Inputs above 9999 saturate to 16'h9999 with ovf set; the saturation
// decision is made when the value is captured, so the fifth accumulator
// digit is never needed at the output.
module bcd_conv
  import bcd_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic [15:0]     bcd_out,
  output logic            ovf,
  output logic            busy,
  output logic            done
);

  localparam int ACC_W = 4 * BCD_DIGITS_INT;
  localparam int CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  acc_adj;
  logic [IN_W-1:0]   work;
  logic [IN_W-1:0]   work_nxt;
  logic              ovf_pending;
  logic              ovf_pending_nxt;
  logic [15:0]       bcd_out_nxt;
  logic              ovf_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [ACC_W+IN_W-1:0] shifted;

  // One corrector per accumulator digit; digits are corrected independently.
  for (genvar i = 0; i < BCD_DIGITS_INT; i++) begin : g_adj
    bcd_adj3 u_adj3 (
      .digit (acc[4*i +: 4]),
      .fixed (acc_adj[4*i +: 4])
    );
  end

  // Corrected accumulator and working register move left as one word.
  assign shifted = {acc_adj, work} << 1;

  // Next-state, datapath and output-register values; everything holds by default.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    acc_nxt         = acc;
    work_nxt        = work;
    ovf_pending_nxt = ovf_pending;
    bcd_out_nxt     = bcd_out;
    ovf_nxt         = ovf;
    busy_nxt        = busy;
    done_nxt        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          work_nxt        = bin_in;
          acc_nxt         = '0;
          cnt_nxt         = '0;
          ovf_pending_nxt = (32'(bin_in) > BCD_MAX);
          busy_nxt        = 1'b1;
          state_nxt       = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end

      SHIFT: begin
        acc_nxt  = shifted[ACC_W+IN_W-1:IN_W];
        work_nxt = shifted[IN_W-1:0];
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = SHIFT;
        end
      end

      FINISH: begin
        if (ovf_pending) begin
          bcd_out_nxt = BCD_SAT;
        end else begin
          bcd_out_nxt = acc[15:0];
        end
        ovf_nxt   = ovf_pending;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Single register stage for state, counter, datapath and outputs; reset aborts silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      work        <= '0;
      ovf_pending <= 1'b0;
      bcd_out     <= 16'h0000;
      ovf         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      work        <= work_nxt;
      ovf_pending <= ovf_pending_nxt;
      bcd_out     <= bcd_out_nxt;
      ovf         <= ovf_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule : bcd_conv

// File: tb/tb_bcd_conv.sv
// Self-checking bench for bcd_conv: directed boundary cases plus random
// values, checked against a decimal-arithmetic reference model.
module tb_bcd_conv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic [15:0] bcd_out;
  logic        ovf;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  localparam int LATENCY = 17;

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  bcd_conv #(.IN_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [15:0] exp_bcd(input int unsigned v);
    if (v > 32'd9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_conv(input int unsigned v);
    bin_in = 16'(v);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Waits (bounded) for done after a start edge; optionally scrambles bin_in
  // and raises a stray start at cycle poke_at. Returns in the done cycle.
  task automatic wait_finish(input int unsigned v, input bit noise, input int poke_at);
    int n        = 0;
    int busy_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (noise) bin_in = 16'($urandom);
      if (n == poke_at) begin
        start  = 1'b1;
        bin_in = 16'd777;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check_eq($sformatf("done_seen[%0d]", v), 32'(done), 32'd1);
    check_eq($sformatf("latency[%0d]", v), n, LATENCY);
    check_eq($sformatf("busy_cycles[%0d]", v), busy_cnt, LATENCY);
    check_eq($sformatf("busy_at_done[%0d]", v), 32'(busy), 32'd0);
    check_eq($sformatf("bcd_out[%0d]", v), 32'(bcd_out), 32'(exp_bcd(v)));
    check_eq($sformatf("ovf[%0d]", v), 32'(ovf), (v > 32'd9999) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int unsigned sweep[8] = '{0, 9, 10, 99, 100, 999, 1000, 9999};
    int unsigned big[2]   = '{10000, 65535};
    int unsigned v;
    int unsigned r;

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: outputs stay at their reset values.
    for (int i = 0; i < 50; i++) begin
      check_eq("rst_bcd_out", 32'(bcd_out), 32'h0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      tick();
    end

    // Basic conversion and one-cycle done pulse.
    start_conv(1234);
    wait_finish(1234, 1'b0, -1);
    check_eq("bcd_1234", 32'(bcd_out), 32'h1234);
    tick();
    check_eq("done_pulse_width", 32'(done), 32'd0);
    check_eq("bcd_hold", 32'(bcd_out), 32'h1234);

    // Digit-count boundaries.
    foreach (sweep[i]) begin
      start_conv(sweep[i]);
      wait_finish(sweep[i], 1'b0, -1);
      tick();
    end

    // Saturation, then recovery.
    foreach (big[i]) begin
      start_conv(big[i]);
      wait_finish(big[i], 1'b0, -1);
      check_eq("sat_word", 32'(bcd_out), 32'h9999);
      tick();
    end
    start_conv(42);
    wait_finish(42, 1'b0, -1);
    check_eq("after_sat_42", 32'(bcd_out), 32'h0042);
    tick();

    // Stray start while busy is ignored; a start in the done cycle is taken.
    start_conv(4321);
    wait_finish(4321, 1'b1, 5);
    start_conv(777);
    wait_finish(777, 1'b1, -1);
    check_eq("reissue_777", 32'(bcd_out), 32'h0777);
    tick();

    // Reset mid-conversion aborts without a done pulse.
    start_conv(5555);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      tick();
    end
    check_eq("abort_bcd_out", 32'(bcd_out), 32'h0);
    check_eq("abort_ovf", 32'(ovf), 32'd0);
    start_conv(5555);
    wait_finish(5555, 1'b0, -1);
    tick();

    // Random values biased toward the saturation boundary, with noise and stray starts.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0) v = $urandom_range(0, 65535);
      else if (r == 1) v = $urandom_range(9990, 10010);
      else v = $urandom_range(0, 9999);
      start_conv(v);
      wait_finish(v, 1'b1, int'($urandom_range(1, 15)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcd_conv
